// File: rtl/updown_sched_pkg.sv
// Shared types and constants for the up/down step sequencer.
package updown_sched_pkg;

  localparam int N_REQ     = 2;
  localparam int DEF_WIDTH = 2;
  localparam int DEF_LEN_W = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/updown_step_counter.sv
// Step counter register with wrap detection.
// Optional feature: define UPDOWN_SATURATE_EN to clamp at 0 / 2^WIDTH-1
// instead of wrapping; wrap then pulses for every suppressed step.
module updown_step_counter #(
  parameter int WIDTH = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             dir,
  output logic [WIDTH-1:0] q,
  output logic             wrap
);

  logic [WIDTH-1:0] q_step;
  logic [WIDTH-1:0] q_nxt;
  logic             crosses;

  // Next counter value and whether this step crosses the range boundary.
  always_comb begin
    crosses = dir ? (q == {WIDTH{1'b1}}) : (q == '0);
    q_step  = dir ? (q + WIDTH'(1)) : (q - WIDTH'(1));
`ifdef UPDOWN_SATURATE_EN
    q_nxt   = crosses ? q : q_step;
`else
    q_nxt   = q_step;
`endif
  end

  // Counter register; wrap is registered so it lines up with the new q.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q    <= '0;
      wrap <= 1'b0;
    end else begin
      if (en) q <= q_nxt;
      wrap <= en && crosses;
    end
  end

endmodule

// File: rtl/updown_step_sched.sv
// Round-robin two-way arbiter and burst sequencer for the up/down step
// counter. Optional feature macro: UPDOWN_SATURATE_EN (see counter).
//
// Handshake: a requester raises req[i] with dir/len stable and holds it
// until grant[i] pulses (grant acts as the acceptance strobe); it must drop
// req in the following cycle. req/dir/len are only looked at in IDLE.
module updown_step_sched
  import updown_sched_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int LEN_W = DEF_LEN_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_REQ-1:0] req,
  input  logic             dir0,
  input  logic             dir1,
  input  logic [LEN_W-1:0] len0,
  input  logic [LEN_W-1:0] len1,
  output logic [N_REQ-1:0] grant,
  output logic             busy,
  output logic             done,
  output logic             done_id,
  output logic [WIDTH-1:0] q,
  output logic             wrap,
  output state_t           dbg_state
);

  state_t           state, state_nxt;
  logic [N_REQ-1:0] grant_nxt;
  logic [LEN_W-1:0] rem;
  logic [LEN_W-1:0] win_len;
  logic             win_id, win_dir;
  logic             load, step_en;
  logic             id_q, dir_q, last_id;

  // Arbiter: single requester wins outright; on a tie the one not served last wins.
  always_comb begin
    win_id  = (&req) ? ~last_id : req[1];
    win_len = win_id ? len1 : len0;
    win_dir = win_id ? dir1 : dir0;
  end

  // Next-state and control decode.
  always_comb begin
    state_nxt = state;
    grant_nxt = '0;
    load      = 1'b0;
    step_en   = 1'b0;
    case (state)
      IDLE: begin
        if (|req) begin
          load      = 1'b1;
          grant_nxt = N_REQ'(1) << win_id;
          state_nxt = (win_len != '0) ? RUN : DONE;
        end
      end
      RUN: begin
        step_en = 1'b1;
        if (rem == LEN_W'(1)) state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State, grant pulse and latched burst parameters.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      grant   <= '0;
      rem     <= '0;
      id_q    <= 1'b0;
      dir_q   <= 1'b0;
      last_id <= 1'b1;
    end else begin
      state <= state_nxt;
      grant <= grant_nxt;
      if (load) begin
        rem   <= win_len;
        id_q  <= win_id;
        dir_q <= win_dir;
      end else if (step_en) begin
        rem <= rem - LEN_W'(1);
      end
      if (state == DONE) last_id <= id_q;
    end
  end

  // Moore-decoded status outputs.
  always_comb begin
    busy      = (state == RUN) || (state == DONE);
    done      = (state == DONE);
    done_id   = (state == DONE) ? id_q : 1'b0;
    dbg_state = state;
  end

  updown_step_counter #(.WIDTH(WIDTH)) u_counter (
    .clk   (clk),
    .reset (reset),
    .en    (step_en),
    .dir   (dir_q),
    .q     (q),
    .wrap  (wrap)
  );

endmodule

// File: doc/updown_step_sched.md
# updown_step_sched

Sequencer and two-way arbiter for the shared up/down step counter. Two requesters each ask for a burst of N single steps in a chosen direction. The block grants one requester at a time using round-robin, drives the counter one step per cycle, and reports completion and wrap-around. It sits between the requester logic and the counter datapath, and it owns the counter state.

## Interface
- `WIDTH`, default 2: counter width in bits.
- `LEN_W`, default 3: burst-length field width; maximum burst is 2^LEN_W-1 steps.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-low reset (asserted at 0).
- `req`  in  2  request, one bit per requester; held high until granted.
- `dir0`, `dir1`  in  1 each  direction for each requester: 1 = up, 0 = down.
- `len0`, `len1`  in  LEN_W each  number of steps for each requester.
- `grant`  out  2  one-cycle, one-hot pulse marking the accepted requester.
- `busy`  out  1  high while a burst is in progress (states RUN and DONE).
- `done`  out  1  one-cycle pulse when the burst finishes.
- `done_id`  out  1  index of the requester whose burst finished; valid with `done`.
- `q`  out  WIDTH  counter value.
- `wrap`  out  1  one-cycle pulse: the previous step wrapped (or saturated; see Configuration).

## Operation
- The FSM has three states: IDLE, RUN and DONE.
- IDLE:
  - If `req` is nonzero, select a winner.
  - If only one requester is asserting, that requester wins.
  - If both are asserting, the winner is the requester that was not granted last (`last_id`).
  - Latch the winner's `dir`, `len` and id, pulse `grant[id]`, and set `rem` = len.
  - Next state is RUN if len != 0, otherwise DONE (zero-length burst: no step is taken).
- RUN:
  - On every cycle: `q` <= q±1 (mod 2^WIDTH) and `rem` <= rem-1.
  - When `rem`==1, next state is DONE.
- DONE:
  - `done` = 1 and `done_id` = latched id.
  - `last_id` <= id.
  - Next state is IDLE.
- `req`, `dir` and `len` are sampled only in IDLE. Changes while `busy` is high are ignored.
- A requester must deassert `req` in the cycle after its `grant`. If `req` is still high when the block returns to IDLE, it is treated as a new request.
- Wrap:
  - Stepping up from 2^WIDTH-1 to 0 sets `wrap` = 1 for one cycle, coincident with the new `q`.
  - Stepping down from 0 to 2^WIDTH-1 does the same.
- Reset values: state IDLE, `q`=0, `rem`=0, `last_id`=1 (so requester 0 wins the first tie), and `grant`, `busy`, `done`, `done_id`, `wrap` all 0.
- Reset asserted mid-burst: the burst is abandoned, no `done` is issued, and `q` returns to 0.

## Timing
- `req` is sampled at the edge ending cycle n (state IDLE). `grant` is high in cycle n+1.
- Step k of the burst is visible on `q` in cycle n+1+k.
- `done` is high in cycle n+len+1, the same cycle that `q` shows its final value.
- The block is back in IDLE in cycle n+len+2. The next `grant` can come no earlier than cycle n+len+3.
- For len=0, `grant` and `done` are both high in cycle n+1.
- All outputs are registered or Moore-decoded from registered state. No input reaches an output combinationally.
- Throughput is one step per cycle, plus 2 cycles of overhead per burst.

## Configuration
- `UPDOWN_SATURATE_EN` defined:
  - Steps that would wrap are suppressed and `q` holds at 2^WIDTH-1 or 0.
  - `wrap` pulses for each suppressed step.
  - `rem` still decrements, so burst timing is unchanged.
- `UPDOWN_SATURATE_EN` not defined: modular wrap-around as described in Operation.

## Structure
- Shared package `updown_sched_pkg` holds:
  - The state enum (IDLE, RUN, DONE).
  - The requester count constant `N_REQ`=2.
  - Default `WIDTH` and `LEN_W` constants.
- One sub-module, `updown_step_counter` (ports: `en`, `dir`, `q`, `wrap`), holds the counter register and the wrap/saturate logic. It is built on the team's D flip-flop style with the same asynchronous active-low reset.
- The top level holds the FSM, arbiter, `rem` and `last_id`.

## Test plan
- Reset, then `req`=01, `dir0`=1, `len0`=3 (WIDTH=2) -> `grant`=01 in cycle 1; `q` reads 1, 2, 3 in cycles 2–4; `done`=1 with `done_id`=0 in cycle 4.
- From `q`=3, `req`=10, `dir1`=1, `len1`=2 -> `q` reads 0 then 1; `wrap` pulses with `q`=0. With `UPDOWN_SATURATE_EN`: `q` reads 3 then 3, and `wrap` pulses twice.
- `req`=11 held continuously with len=1 for both -> grants alternate 01, 10, 01, starting with requester 0.
- `len0`=0 -> `grant` and `done` both high in the same cycle; `q` unchanged; back in IDLE the following cycle.
- `reset` asserted (driven low) in the middle of a 5-step burst -> all outputs 0 immediately; no `done` is issued; after release, a new request is granted normally.
- Change `dir0` and `len0` while `busy`=1 -> the burst completes using the originally latched values.
